// File: rtl/ysyx_22050078_seq_ctrl_pkg.sv
// Shared definitions for the ysyx_22050078 multi-cycle sequencer:
// state encoding, halt reason codes and the LSU no-op opcode.
package ysyx_22050078_seq_ctrl_pkg;

    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    typedef enum logic [2:0] {
        S_RESET  = ST_RESET,
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_MEM    = ST_MEM,
        S_WB     = ST_WB,
        S_HALT   = ST_HALT
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_DECODE  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Decoder LSU opcode meaning "no memory access"; compared after width cast.
    localparam int unsigned LSU_NOP = 0;

endpackage

// File: rtl/ysyx_22050078_wdog.sv
// Handshake watchdog: counts up while enabled, saturates at LIMIT-1 and
// flags terminal count there; a clear returns it to zero.
module ysyx_22050078_wdog #(
    parameter int unsigned LIMIT = 255,
    parameter int unsigned W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !tc) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    // tc is high on the LIMIT-th cycle spent in a counting state
    assign tc = (cnt_q >= LAST);

endmodule

// File: rtl/ysyx_22050078_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch, decode, optional execute and
// memory phases, writeback; halts on ebreak, decode error or bus timeout.
module ysyx_22050078_seq_ctrl
    import ysyx_22050078_seq_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned CNT_W     = 64,
    parameter int unsigned LSU_OPT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_if_gnt,
    input  logic                 i_if_rvalid,
    input  logic                 i_rd_wen,
    input  logic [LSU_OPT_W-1:0] i_lsu_opt,
    input  logic                 i_store,
    input  logic                 i_ebreak,
    input  logic [2:0]           i_id_err,
    input  logic                 i_exu_multi,
    input  logic                 i_exu_done,
    input  logic                 i_lsu_gnt,
    input  logic                 i_lsu_rvalid,
    output logic                 o_if_req,
    output logic                 o_ir_we,
    output logic                 o_exu_start,
    output logic                 o_lsu_req,
    output logic                 o_rf_we,
    output logic                 o_pc_we,
    output logic                 o_halt,
    output logic [1:0]           o_err,
    output logic [2:0]           o_state,
    output logic [CNT_W-1:0]     o_cycle_cnt,
    output logic [CNT_W-1:0]     o_instret
);

    state_e           state_q, state_d;
    logic [1:0]       err_q, err_d;
    logic             gnt_q;
    logic             wd_tc, wd_clr, wd_en;
    logic [CNT_W-1:0] cyc_q, ret_q;

    logic is_load, is_mem, if_hit, ld_hit, mem_done;
    logic ir_we, exu_start, rf_we;

    assign is_load = (i_lsu_opt != LSU_OPT_W'(LSU_NOP));
    assign is_mem  = is_load || i_store;

    // rvalid is only accepted once the request has been granted (or with the grant)
    assign if_hit   = i_if_rvalid && (gnt_q || i_if_gnt);
    assign ld_hit   = i_lsu_rvalid && (gnt_q || i_lsu_gnt);
    assign mem_done = i_store ? i_lsu_gnt : ld_hit;

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        ir_we     = 1'b0;
        exu_start = 1'b0;
        rf_we     = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                if (if_hit) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (wd_tc && !i_if_gnt) begin
                    state_d = S_HALT;
                    err_d   = ERR_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (i_id_err != 3'b000) begin
                    state_d = S_HALT;
                    err_d   = ERR_DECODE;
                end else if (i_ebreak) begin
                    state_d = S_HALT;
                    err_d   = ERR_NONE;
                end else if (i_exu_multi) begin
                    exu_start = 1'b1;
                    state_d   = S_EXEC;
                end else if (is_mem) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_EXEC: begin
                if (i_exu_done) begin
                    state_d = is_mem ? S_MEM : S_WB;
                end else if (wd_tc) begin
                    state_d = S_HALT;
                    err_d   = ERR_TIMEOUT;
                end
            end
            S_MEM: begin
                if (mem_done) begin
                    state_d = S_WB;
                end else if (wd_tc && !i_lsu_gnt) begin
                    state_d = S_HALT;
                    err_d   = ERR_TIMEOUT;
                end
            end
            S_WB: begin
                rf_we   = i_rd_wen;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    assign wd_clr = (state_d != state_q);
    assign wd_en  = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_MEM);

    ysyx_22050078_wdog #(
        .LIMIT (TIMEOUT)
    ) u_wdog (
        .clk (clk),
        .rst (rst),
        .clr (wd_clr),
        .en  (wd_en),
        .tc  (wd_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RESET;
            err_q   <= ERR_NONE;
            gnt_q   <= 1'b0;
            cyc_q   <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            // grant flag lives for one handshake state only
            if (state_d != state_q) begin
                gnt_q <= 1'b0;
            end else if ((state_q == S_FETCH && i_if_gnt) || (state_q == S_MEM && i_lsu_gnt)) begin
                gnt_q <= 1'b1;
            end
            if (state_q != S_RESET && state_q != S_HALT) begin
                cyc_q <= cyc_q + CNT_W'(1);
            end
            if (state_q == S_WB) begin
                ret_q <= ret_q + CNT_W'(1);
            end
        end
    end

    assign o_if_req    = (state_q == S_FETCH) && !gnt_q;
    assign o_lsu_req   = (state_q == S_MEM) && !gnt_q;
    assign o_pc_we     = (state_q == S_WB);
    assign o_halt      = (state_q == S_HALT);
    assign o_state     = state_q;
    assign o_ir_we     = ir_we;
    assign o_exu_start = exu_start;
    assign o_rf_we     = rf_we;
    assign o_err       = err_q;
    assign o_cycle_cnt = cyc_q;
    assign o_instret   = ret_q;

endmodule

// File: tb/tb_ysyx_22050078_seq_ctrl.sv
// Bench for the sequencer: a per-instruction planner expands each scenario
// into expected per-cycle outputs, which are checked every cycle.
module tb_ysyx_22050078_seq_ctrl;

    localparam int TIMEOUT = 255;

    localparam int K_ALU    = 0;
    localparam int K_LOAD   = 1;
    localparam int K_STORE  = 2;
    localparam int K_MUL    = 3;
    localparam int K_MULLD  = 4;
    localparam int K_EBREAK = 5;
    localparam int K_IDERR  = 6;
    localparam int K_HANG   = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_gnt = 0, if_rvalid = 0, rd_wen = 0, store = 0, ebreak = 0;
    logic [3:0]  lsu_opt = '0;
    logic [2:0]  id_err = '0;
    logic        exu_multi = 0, exu_done = 0, lsu_gnt = 0, lsu_rvalid = 0;
    logic        if_req, ir_we, exu_start, lsu_req, rf_we, pc_we, halt;
    logic [1:0]  err;
    logic [2:0]  state;
    logic [63:0] cycle_cnt, instret;

    ysyx_22050078_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .i_if_gnt    (if_gnt),
        .i_if_rvalid (if_rvalid),
        .i_rd_wen    (rd_wen),
        .i_lsu_opt   (lsu_opt),
        .i_store     (store),
        .i_ebreak    (ebreak),
        .i_id_err    (id_err),
        .i_exu_multi (exu_multi),
        .i_exu_done  (exu_done),
        .i_lsu_gnt   (lsu_gnt),
        .i_lsu_rvalid(lsu_rvalid),
        .o_if_req    (if_req),
        .o_ir_we     (ir_we),
        .o_exu_start (exu_start),
        .o_lsu_req   (lsu_req),
        .o_rf_we     (rf_we),
        .o_pc_we     (pc_we),
        .o_halt      (halt),
        .o_err       (err),
        .o_state     (state),
        .o_cycle_cnt (cycle_cnt),
        .o_instret   (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, if_gnt, if_rvalid, rd_wen, store, ebreak;
        logic [3:0]  lsu_opt;
        logic [2:0]  id_err;
        logic        exu_multi, exu_done, lsu_gnt, lsu_rvalid;
        logic [2:0]  st;
        logic        if_req, ir_we, exu_start, lsu_req, rf_we, pc_we, halt;
        logic [1:0]  err;
        logic [63:0] cyc, ret;
    } ent_t;

    ent_t        plan[$];
    logic [63:0] m_cycle, m_instret;
    int          n_cmp = 0, n_bad = 0, cyc_idx = 0;
    int          st_tally[8];
    int          n_ir = 0, n_exs = 0, n_rf = 0, n_pc = 0;
    int          s_st[8];
    int          s_ir, s_exs, s_rf, s_pc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h want %0h", nm, cyc_idx, act, exp);
        end
    endtask

    // Model bookkeeping: active cycles are every state but RESET/HALT, retire on WB
    task automatic add(input ent_t e_in);
        ent_t e;
        e     = e_in;
        e.cyc = m_cycle;
        e.ret = m_instret;
        if (e.st >= 3'd1 && e.st <= 3'd5) m_cycle++;
        if (e.st == 3'd5) m_instret++;
        plan.push_back(e);
    endtask

    task automatic plan_halt(input ent_t b, input logic [1:0] code, input int n);
        ent_t e;
        for (int k = 0; k < n; k++) begin
            e = b; e.st = 3'd6; e.halt = 1'b1; e.err = code;
            add(e);
        end
    endtask

    task automatic plan_reset();
        ent_t e;
        e = '{default: '0};
        m_cycle = '0; m_instret = '0;
        e.rst = 1'b1;
        add(e);
        add(e);
        e.rst = 1'b0;
        add(e);
    endtask

    task automatic plan_instr(input int kind, input int fg, input int fr, input int stray,
                              input int ed, input int mg, input int mr, input logic rdw);
        ent_t b, e;
        int   mend;
        b = '{default: '0};
        b.rd_wen = rdw;
        case (kind)
            K_LOAD:   b.lsu_opt = 4'h3;
            K_STORE:  b.store = 1'b1;
            K_MUL:    b.exu_multi = 1'b1;
            K_MULLD:  begin b.exu_multi = 1'b1; b.lsu_opt = 4'h5; end
            K_EBREAK: b.ebreak = 1'b1;
            K_IDERR:  begin b.id_err = 3'b010; b.ebreak = 1'b1; end
            default:  ;
        endcase
        if (kind == K_HANG) begin
            for (int k = 0; k < TIMEOUT; k++) begin
                e = b; e.st = 3'd1; e.if_req = 1'b1;
                add(e);
            end
            plan_halt(b, 2'b10, 3);
            return;
        end
        for (int k = 0; k <= fr; k++) begin
            e = b; e.st = 3'd1;
            e.if_req    = (k <= fg);
            e.if_gnt    = (k == fg);
            e.if_rvalid = (k == fr) || (k == stray);
            e.ir_we     = (k == fr);
            add(e);
        end
        e = b; e.st = 3'd2;
        e.exu_start = (kind == K_MUL || kind == K_MULLD);
        add(e);
        if (kind == K_EBREAK) begin plan_halt(b, 2'b00, 3); return; end
        if (kind == K_IDERR)  begin plan_halt(b, 2'b01, 3); return; end
        if (kind == K_MUL || kind == K_MULLD) begin
            for (int k = 0; k <= ed; k++) begin
                e = b; e.st = 3'd3; e.exu_done = (k == ed);
                add(e);
            end
        end
        if (kind == K_LOAD || kind == K_STORE || kind == K_MULLD) begin
            mend = (kind == K_STORE) ? mg : mr;
            for (int k = 0; k <= mend; k++) begin
                e = b; e.st = 3'd4;
                e.lsu_req    = (k <= mg);
                e.lsu_gnt    = (k == mg);
                e.lsu_rvalid = (kind != K_STORE) && (k == mr);
                add(e);
            end
        end
        e = b; e.st = 3'd5; e.rf_we = rdw; e.pc_we = 1'b1;
        add(e);
    endtask

    task automatic run_n(input int n);
        ent_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            e = plan.pop_front();
            rst = e.rst; if_gnt = e.if_gnt; if_rvalid = e.if_rvalid; rd_wen = e.rd_wen;
            store = e.store; ebreak = e.ebreak; lsu_opt = e.lsu_opt; id_err = e.id_err;
            exu_multi = e.exu_multi; exu_done = e.exu_done;
            lsu_gnt = e.lsu_gnt; lsu_rvalid = e.lsu_rvalid;
            @(negedge clk);
            chk("state", 64'(state), 64'(e.st));
            chk("if_req", 64'(if_req), 64'(e.if_req));
            chk("ir_we", 64'(ir_we), 64'(e.ir_we));
            chk("exu_start", 64'(exu_start), 64'(e.exu_start));
            chk("lsu_req", 64'(lsu_req), 64'(e.lsu_req));
            chk("rf_we", 64'(rf_we), 64'(e.rf_we));
            chk("pc_we", 64'(pc_we), 64'(e.pc_we));
            chk("halt", 64'(halt), 64'(e.halt));
            chk("err", 64'(err), 64'(e.err));
            chk("cycle_cnt", cycle_cnt, e.cyc);
            chk("instret", instret, e.ret);
            st_tally[state]++;
            n_ir += int'(ir_we); n_exs += int'(exu_start);
            n_rf += int'(rf_we); n_pc += int'(pc_we);
            cyc_idx++;
        end
    endtask

    task automatic run_all();
        run_n(plan.size());
    endtask

    task automatic snap();
        for (int i = 0; i < 8; i++) s_st[i] = st_tally[i];
        s_ir = n_ir; s_exs = n_exs; s_rf = n_rf; s_pc = n_pc;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) st_tally[i] = 0;
        m_cycle = '0; m_instret = '0;

        plan_reset();
        run_all();

        // ALU, gnt+rvalid together: FETCH, DECODE, WB
        snap();
        plan_instr(K_ALU, 0, 0, -1, 0, 0, 0, 1'b1);
        run_all();
        chk("alu_fetch_len", 64'(st_tally[1] - s_st[1]), 64'd1);
        chk("alu_wb_len", 64'(st_tally[5] - s_st[5]), 64'd1);
        chk("alu_rf_we", 64'(n_rf - s_rf), 64'd1);

        // load, stray rvalid before fetch grant, lsu gnt late by 2, rvalid 3 after
        snap();
        plan_instr(K_LOAD, 1, 2, 0, 0, 2, 5, 1'b1);
        run_all();
        chk("ld_fetch_len", 64'(st_tally[1] - s_st[1]), 64'd3);
        chk("ld_mem_len", 64'(st_tally[4] - s_st[4]), 64'd6);
        chk("ld_rf_we", 64'(n_rf - s_rf), 64'd1);

        snap();
        plan_instr(K_STORE, 0, 1, -1, 0, 0, 0, 1'b0);
        run_all();
        chk("st_mem_len", 64'(st_tally[4] - s_st[4]), 64'd1);
        chk("st_pc_we", 64'(n_pc - s_pc), 64'd1);

        snap();
        plan_instr(K_MUL, 0, 0, -1, 9, 0, 0, 1'b1);
        run_all();
        chk("mul_start", 64'(n_exs - s_exs), 64'd1);
        chk("mul_exec_len", 64'(st_tally[3] - s_st[3]), 64'd10);

        plan_instr(K_MULLD, 2, 2, -1, 0, 0, 0, 1'b1);
        run_all();

        plan_instr(K_EBREAK, 0, 0, -1, 0, 0, 0, 1'b0);
        run_all();
        chk("ebreak_instret", instret, 64'd5);
        chk("ebreak_cycles", cycle_cnt, 64'd41);
        chk("ebreak_err", 64'(err), 64'd0);

        // reset in the middle of MEM, then a fresh instruction
        plan_reset();
        run_all();
        plan_instr(K_LOAD, 0, 0, -1, 0, 3, 4, 1'b1);
        run_n(4);
        plan.delete();
        plan_reset();
        snap();
        plan_instr(K_ALU, 0, 0, -1, 0, 0, 0, 1'b1);
        run_all();
        chk("rst_rf_we", 64'(n_rf - s_rf), 64'd1);
        chk("rst_cycles", cycle_cnt, 64'd2);

        // decode error wins over ebreak
        snap();
        plan_instr(K_IDERR, 0, 0, -1, 0, 0, 0, 1'b1);
        run_all();
        chk("iderr_err", 64'(err), 64'd1);
        chk("iderr_pc_we", 64'(n_pc - s_pc), 64'd0);
        chk("iderr_cycles", cycle_cnt, 64'd5);
        chk("iderr_instret", instret, 64'd1);

        plan_reset();
        run_all();
        snap();
        plan_instr(K_HANG, 0, 0, -1, 0, 0, 0, 1'b0);
        run_all();
        chk("to_fetch_len", 64'(st_tally[1] - s_st[1]), 64'd255);
        chk("to_err", 64'(err), 64'd2);
        chk("to_cycles", cycle_cnt, 64'd255);
        chk("to_halt", 64'(halt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
